cache_tag_lookup: RTL
=====================

CACHE_TAG_LOOKUP -- requirements
Module: cache_tag_lookup

Interface
REQ-001 Parameter ADDR_W, 32, request address width in bits.
REQ-002 Parameter OFFSET_W, 6, log2 of line size in bytes.
REQ-003 Parameter CAP_W, 14, log2 of cache capacity in bytes.
REQ-004 Parameter WAYS_LOG2, 2, log2 of associativity; legal range 1..4.
REQ-005 Derived: INDEX_W = CAP_W-OFFSET_W-WAYS_LOG2, SETS = 2^INDEX_W, TAG_W = ADDR_W-INDEX_W-OFFSET_W; all SHALL be >= 1.
REQ-006 clk  in  1  sole clock; all state updates on rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 req_valid  in  1  request present.
REQ-009 req_ready  out  1  block can accept a request.
REQ-010 req_op  in  2  00 read, 01 write, 10 invalidate, 11 clear-all.
REQ-011 req_addr  in  ADDR_W  byte address.
REQ-012 rsp_valid  out  1  response present.
REQ-013 rsp_ready  in  1  consumer accepts response.
REQ-014 rsp_hit  out  1  tag matched a valid way.
REQ-015 rsp_way  out  WAYS_LOG2  way hit or allocated.
REQ-016 rsp_evict  out  1  a valid line was displaced or invalidated.
REQ-017 rsp_evict_dirty  out  1  displaced/invalidated line was dirty (writeback needed).
REQ-018 rsp_evict_addr  out  ADDR_W  {victim tag, index, OFFSET_W zeros}.
REQ-019 busy  out  1  high in every state except IDLE.

Function
REQ-020 Field split SHALL be: offset = addr[OFFSET_W-1:0], index = addr[OFFSET_W+INDEX_W-1:OFFSET_W], tag = remaining upper bits.
REQ-021 Each set/way SHALL hold valid, dirty, TAG_W tag, WAYS_LOG2 LRU age; ages within a set are always a permutation of 0..WAYS-1.
REQ-022 FSM states SHALL be IDLE, LOOKUP, CLEAR, RESP; req_ready = 1 only in IDLE.
REQ-023 On req_valid && req_ready, addr/op latched; next state LOOKUP (ops 00-10) or CLEAR (op 11).
REQ-024 LOOKUP lasts exactly one cycle; array update and response registers written on the edge leaving LOOKUP; rsp_valid high in the following cycle (2 edges after acceptance).
REQ-025 Hit = any way valid with matching tag; multiple matches cannot occur.
REQ-026 Miss victim = lowest-numbered invalid way, else the way with age WAYS-1.
REQ-027 Read hit: touch way. Write hit: dirty=1, touch. Both: rsp_evict=0.
REQ-028 Read miss: victim valid=1, dirty=0, tag loaded, touch. Write miss: same but dirty=1 (write-allocate).
REQ-029 Miss rsp_evict=1 only if victim was valid; rsp_evict_dirty = victim dirty; else both 0 and rsp_evict_addr=0.
REQ-030 Invalidate hit: valid=0, dirty=0, rsp_hit=1, rsp_evict=1, evict_dirty/addr from line, ages unchanged. Invalidate miss: no state change, all rsp flags 0.
REQ-031 Touch: accessed way age=0; every way with age lower than its old age increments; others unchanged.
REQ-032 CLEAR: one set per cycle, index 0..SETS-1, valid=dirty=0, age=way number; after SETS cycles enter RESP with rsp_hit=rsp_evict=0.
REQ-033 RESP: rsp_* held stable while rsp_valid && !rsp_ready; on rsp_ready go IDLE; next request accepted earliest the cycle after.
REQ-034 req_addr/req_op changes while req_ready=0 SHALL be ignored.

Reset
REQ-035 rst_n low SHALL immediately: FSM=IDLE, all valid/dirty=0, age=way number in every set, rsp_valid=rsp_hit=rsp_evict=rsp_evict_dirty=0, rsp_way=0, rsp_evict_addr=0, busy=0, req_ready=1.
REQ-036 Reset mid-operation (LOOKUP, CLEAR, RESP) SHALL drop the transaction with no response.

Verification (defaults: 64 sets, 4 ways, TAG_W=20)
REQ-037 Reset, read 0x00001040 -> miss, way 0, evict 0, rsp_valid 2 edges after accept; repeat -> hit way 0.
REQ-038 Reads 0x40,0x1040,0x2040,0x3040 -> misses ways 0-3; read 0x4040 -> miss way 0, evict=1, dirty=0, evict_addr=0x00000040.
REQ-039 Fill set 1 as above, read 0x40 (hit way 0), read 0x5040 -> victim way 1, evict_addr=0x00001040.
REQ-040 Write 0x80 (miss, way 0), reads 0x1080,0x2080,0x3080, read 0x4080 -> evict=1, evict_dirty=1, evict_addr=0x00000080.
REQ-041 Invalidate dirty line with rsp_ready=0 for 5 cycles -> hit=1, evict_dirty=1, outputs stable, req_ready=0 throughout.
REQ-042 Clear-all -> busy for 64 CLEAR cycles + RESP, prior hits then miss; rst_n low during LOOKUP -> rsp_valid stays 0, same address later misses.

Source files
------------

// File: rtl/cache_tag_lookup.sv
// Set-associative cache tag/state array with true-LRU replacement.
// One request per transaction: lookup in one cycle, clear-all one set per cycle.
module cache_tag_lookup #(
    parameter int ADDR_W    = 32,
    parameter int OFFSET_W  = 6,
    parameter int CAP_W     = 14,
    parameter int WAYS_LOG2 = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [1:0]           req_op,
    input  logic [ADDR_W-1:0]    req_addr,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_hit,
    output logic [WAYS_LOG2-1:0] rsp_way,
    output logic                 rsp_evict,
    output logic                 rsp_evict_dirty,
    output logic [ADDR_W-1:0]    rsp_evict_addr,
    output logic                 busy
);
    localparam int INDEX_W = CAP_W - OFFSET_W - WAYS_LOG2;
    localparam int SETS    = 1 << INDEX_W;
    localparam int WAYS    = 1 << WAYS_LOG2;
    localparam int TAG_W   = ADDR_W - INDEX_W - OFFSET_W;

    typedef enum logic [1:0] {IDLE, LOOKUP, CLEAR, RESP} state_e;
    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_INVAL = 2'b10,
        OP_CLEAR = 2'b11
    } op_e;

    state_e               state_q, state_d;
    logic [INDEX_W-1:0]   clr_q, clr_d;
    op_e                  op_q;
    logic [TAG_W-1:0]     req_tag_q;
    logic [INDEX_W-1:0]   req_idx_q;

    logic                 valid_q [SETS][WAYS];
    logic                 dirty_q [SETS][WAYS];
    logic [TAG_W-1:0]     tags_q  [SETS][WAYS];
    logic [WAYS_LOG2-1:0] ages_q  [SETS][WAYS];

    logic                 rsp_hit_q, rsp_evict_q, rsp_evict_dirty_q;
    logic [WAYS_LOG2-1:0] rsp_way_q;
    logic [ADDR_W-1:0]    rsp_evict_addr_q;

    logic                 hit, found_inv;
    logic [WAYS_LOG2-1:0] hit_way, victim_way, acc_way, acc_age;
    logic [WAYS_LOG2-1:0] touch_age [WAYS];

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        hit        = 1'b0;
        hit_way    = '0;
        found_inv  = 1'b0;
        victim_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[req_idx_q][w] && tags_q[req_idx_q][w] == req_tag_q) begin
                hit     = 1'b1;
                hit_way = WAYS_LOG2'(w);
            end
        end
        // Descending scan leaves the lowest-numbered invalid way selected.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[req_idx_q][w]) begin
                found_inv  = 1'b1;
                victim_way = WAYS_LOG2'(w);
            end
        end
        if (!found_inv) begin
            for (int w = 0; w < WAYS; w++) begin
                if (ages_q[req_idx_q][w] == WAYS_LOG2'(WAYS - 1)) victim_way = WAYS_LOG2'(w);
            end
        end
        acc_way = hit ? hit_way : victim_way;
        acc_age = ages_q[req_idx_q][acc_way];
        for (int w = 0; w < WAYS; w++) begin
            touch_age[w] = ages_q[req_idx_q][w];
            if (WAYS_LOG2'(w) == acc_way)            touch_age[w] = '0;
            else if (ages_q[req_idx_q][w] < acc_age) touch_age[w] = ages_q[req_idx_q][w] + WAYS_LOG2'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        clr_d   = clr_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = (req_op == OP_CLEAR) ? CLEAR : LOOKUP;
                    clr_d   = '0;
                end
            end
            LOOKUP: state_d = RESP;
            CLEAR: begin
                clr_d = clr_q + INDEX_W'(1);
                if (clr_q == INDEX_W'(SETS - 1)) state_d = RESP;
            end
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            clr_q   <= '0;
        end else begin
            state_q <= state_d;
            clr_q   <= clr_d;
        end
    end

    // NOTE: the array is built from flops rather than RAM because reset must clear every line at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    dirty_q[s][w] <= 1'b0;
                    tags_q[s][w]  <= '0;
                    ages_q[s][w]  <= WAYS_LOG2'(w);
                end
            end
            op_q              <= OP_READ;
            req_tag_q         <= '0;
            req_idx_q         <= '0;
            rsp_hit_q         <= 1'b0;
            rsp_way_q         <= '0;
            rsp_evict_q       <= 1'b0;
            rsp_evict_dirty_q <= 1'b0;
            rsp_evict_addr_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        op_q              <= op_e'(req_op);
                        req_tag_q         <= req_addr[ADDR_W-1:OFFSET_W+INDEX_W];
                        req_idx_q         <= req_addr[OFFSET_W+INDEX_W-1:OFFSET_W];
                        rsp_hit_q         <= 1'b0;
                        rsp_way_q         <= '0;
                        rsp_evict_q       <= 1'b0;
                        rsp_evict_dirty_q <= 1'b0;
                        rsp_evict_addr_q  <= '0;
                    end
                end
                LOOKUP: begin
                    case (op_q)
                        OP_READ, OP_WRITE: begin
                            rsp_hit_q <= hit;
                            rsp_way_q <= acc_way;
                            if (!hit && valid_q[req_idx_q][victim_way]) begin
                                rsp_evict_q       <= 1'b1;
                                rsp_evict_dirty_q <= dirty_q[req_idx_q][victim_way];
                                rsp_evict_addr_q  <= {tags_q[req_idx_q][victim_way], req_idx_q,
                                                      {OFFSET_W{1'b0}}};
                            end
                            valid_q[req_idx_q][acc_way] <= 1'b1;
                            tags_q[req_idx_q][acc_way]  <= req_tag_q;
                            dirty_q[req_idx_q][acc_way] <= (op_q == OP_WRITE) ||
                                                           (hit && dirty_q[req_idx_q][acc_way]);
                            for (int w = 0; w < WAYS; w++) ages_q[req_idx_q][w] <= touch_age[w];
                        end
                        OP_INVAL: begin
                            if (hit) begin
                                rsp_hit_q         <= 1'b1;
                                rsp_way_q         <= hit_way;
                                rsp_evict_q       <= 1'b1;
                                rsp_evict_dirty_q <= dirty_q[req_idx_q][hit_way];
                                rsp_evict_addr_q  <= {tags_q[req_idx_q][hit_way], req_idx_q,
                                                      {OFFSET_W{1'b0}}};
                                valid_q[req_idx_q][hit_way] <= 1'b0;
                                dirty_q[req_idx_q][hit_way] <= 1'b0;
                            end
                        end
                        default: ;
                    endcase
                end
                CLEAR: begin
                    for (int w = 0; w < WAYS; w++) begin
                        valid_q[clr_q][w] <= 1'b0;
                        dirty_q[clr_q][w] <= 1'b0;
                        ages_q[clr_q][w]  <= WAYS_LOG2'(w);
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready       = (state_q == IDLE);
    assign busy            = (state_q != IDLE);
    assign rsp_valid       = (state_q == RESP);
    assign rsp_hit         = rsp_hit_q;
    assign rsp_way         = rsp_way_q;
    assign rsp_evict       = rsp_evict_q;
    assign rsp_evict_dirty = rsp_evict_dirty_q;
    assign rsp_evict_addr  = rsp_evict_addr_q;

endmodule
